// File: rtl/shift_cmd_sequencer.sv
// Command FIFO feeding an external combinational shifter, plus a registered output slot.
// Optional result counter (op_count port) enabled by defining SHIFT_STATS_EN.
module shift_cmd_sequencer #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned AMT_W  = 3,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic [AMT_W-1:0]  cmd_amount,
    input  logic              cmd_dir,
    output logic [DATA_W-1:0] sh_data_in,
    output logic [AMT_W-1:0]  sh_shift_amount,
    output logic              sh_shift_direction,
    input  logic [DATA_W-1:0] sh_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
`ifdef SHIFT_STATS_EN
    ,
    output logic [15:0]       op_count
`endif
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned ENT_W = DATA_W + AMT_W + 1;

    logic [ENT_W-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;

    logic              push;
    logic              not_empty;
    logic              load_en;
    logic [ENT_W-1:0]  head;

    assign not_empty = (count_q != '0);
    // Space is judged on the registered count only; a same-cycle pop does not admit a push.
    assign cmd_ready = (count_q != CNT_W'(DEPTH));
    assign push      = cmd_valid && cmd_ready;
    assign load_en   = not_empty && (!out_valid_q || out_ready);
    assign head      = mem_q[rd_ptr_q];

    always_comb begin
        sh_data_in         = '0;
        sh_shift_amount    = '0;
        sh_shift_direction = 1'b0;
        if (not_empty) begin
            sh_data_in         = head[ENT_W-1 -: DATA_W];
            sh_shift_amount    = head[AMT_W:1];
            sh_shift_direction = head[0];
        end
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end

        if (load_en) begin
            out_data_d  = sh_result;
            out_valid_d = 1'b1;
            rd_ptr_d    = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (push && !load_en) begin
            count_d = count_q + 1'b1;
        end else if (!push && load_en) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // Storage needs no reset: entries are only ever read below count_q.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wr_ptr_q] <= {cmd_data, cmd_amount, cmd_dir};
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

`ifdef SHIFT_STATS_EN
    logic [15:0] op_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            op_count_q <= '0;
        end else if (out_valid_q && out_ready && (op_count_q != '1)) begin
            op_count_q <= op_count_q + 16'd1;
        end
    end

    assign op_count = op_count_q;
`endif

endmodule

// File: tb/tb_shift_cmd_sequencer.sv
// Directed bench for shift_cmd_sequencer; models the external shifter combinationally.
// Define SHIFT_STATS_EN to also check op_count.
module tb_shift_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_data;
    logic [2:0] cmd_amount;
    logic       cmd_dir;
    logic [7:0] sh_data_in;
    logic [2:0] sh_shift_amount;
    logic       sh_shift_direction;
    logic [7:0] sh_result;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
`ifdef SHIFT_STATS_EN
    logic [15:0] op_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign sh_result = sh_shift_direction ? (sh_data_in << sh_shift_amount)
                                          : (sh_data_in >> sh_shift_amount);

    shift_cmd_sequencer #(.DATA_W(8), .AMT_W(3), .DEPTH(4)) dut (
        .clk                (clk),
        .rst                (rst),
        .cmd_valid          (cmd_valid),
        .cmd_ready          (cmd_ready),
        .cmd_data           (cmd_data),
        .cmd_amount         (cmd_amount),
        .cmd_dir            (cmd_dir),
        .sh_data_in         (sh_data_in),
        .sh_shift_amount    (sh_shift_amount),
        .sh_shift_direction (sh_shift_direction),
        .sh_result          (sh_result),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .out_data           (out_data)
`ifdef SHIFT_STATS_EN
        ,
        .op_count           (op_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic [2:0] a, input logic dir);
        cmd_valid  = v;
        cmd_data   = d;
        cmd_amount = a;
        cmd_dir    = dir;
    endtask

    initial begin
        logic [7:0] exp3 [5];
        logic [7:0] exp4 [8];
        logic [7:0] q [$];
        logic [7:0] rd, ra_d, model;
        logic [2:0] ra_a;
        logic       ra_dir, acc;
        int         accepted, sent, got;

        exp3 = '{8'h20, 8'h22, 8'h24, 8'h26, 8'h28};
        exp4 = '{8'h02, 8'h04, 8'h06, 8'h08, 8'h0A, 8'h0C, 8'h0E, 8'h10};

        rst = 1'b1;
        out_ready = 1'b0;
        drive(1'b0, 8'h00, 3'd0, 1'b0);
        step();
        step();
        rst = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'h00);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_sh_data", 32'(sh_data_in), 32'h00);

        // Test 1: latency and left shift
        out_ready = 1'b1;
        drive(1'b1, 8'hB5, 3'd3, 1'b1);
        step();
        drive(1'b0, 8'h00, 3'd0, 1'b0);
        chk("t1_no_bypass", 32'(out_valid), 32'd0);
        chk("t1_sh_data", 32'(sh_data_in), 32'hB5);
        chk("t1_sh_amt", 32'(sh_shift_amount), 32'd3);
        step();
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_data", 32'(out_data), 32'hA8);
        step();
        chk("t1_drained", 32'(out_valid), 32'd0);
        chk("t1_sh_idle", 32'(sh_data_in), 32'h00);

        // Test 2: right shift, then zero amount
        drive(1'b1, 8'hB5, 3'd3, 1'b0);
        step();
        drive(1'b1, 8'h3C, 3'd0, 1'b1);
        step();
        drive(1'b0, 8'h00, 3'd0, 1'b0);
        chk("t2_right", 32'(out_data), 32'h16);
        step();
        chk("t2_amt0_valid", 32'(out_valid), 32'd1);
        chk("t2_amt0", 32'(out_data), 32'h3C);
        step();
        chk("t2_drained", 32'(out_valid), 32'd0);

        // Test 3: capacity with stalled consumer, then in-order drain
        out_ready = 1'b0;
        accepted = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 8'(8'h10 + accepted), 3'd1, 1'b1);
            if (cmd_ready) accepted++;
            step();
        end
        drive(1'b0, 8'h00, 3'd0, 1'b0);
        chk("t3_accepted", 32'(accepted), 32'd5);
        chk("t3_full_ready", 32'(cmd_ready), 32'd0);
        chk("t3_hold_valid", 32'(out_valid), 32'd1);
        chk("t3_hold_data", 32'(out_data), 32'h20);
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("t3_drain_valid", 32'(out_valid), 32'd1);
            chk("t3_drain_data", 32'(out_data), 32'(exp3[k]));
            if (k == 1) chk("t3_ready_back", 32'(cmd_ready), 32'd1);
            step();
        end
        chk("t3_empty", 32'(out_valid), 32'd0);

        // Test 4: back-to-back throughput
        for (int i = 0; i < 9; i++) begin
            if (i < 8) drive(1'b1, 8'(i + 1), 3'd1, 1'b1);
            else drive(1'b0, 8'h00, 3'd0, 1'b0);
            step();
            if (i >= 1) begin
                chk("t4_valid", 32'(out_valid), 32'd1);
                chk("t4_data", 32'(out_data), 32'(exp4[i-1]));
                chk("t4_ready", 32'(cmd_ready), 32'd1);
            end
        end
        step();
        chk("t4_drained", 32'(out_valid), 32'd0);

        // Test 5: reset discards queued work
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'(8'h40 + i), 3'd2, 1'b0);
            step();
        end
        chk("t5_pre_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 8'h77, 3'd1, 1'b1);
        step();
        rst = 1'b0;
        drive(1'b0, 8'h00, 3'd0, 1'b0);
        chk("t5_valid", 32'(out_valid), 32'd0);
        chk("t5_ready", 32'(cmd_ready), 32'd1);
        chk("t5_sh_data", 32'(sh_data_in), 32'h00);
        chk("t5_sh_amt", 32'(sh_shift_amount), 32'd0);
        chk("t5_sh_dir", 32'(sh_shift_direction), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t5_no_stale", 32'(out_valid), 32'd0);
        end

        // Test 6: randomized commands against a reference shift
        sent = 0;
        got = 0;
        for (int cyc = 0; cyc < 40 && got < 10; cyc++) begin
            if (sent < 10) begin
                ra_d   = 8'($urandom);
                ra_a   = 3'($urandom_range(7, 0));
                ra_dir = 1'($urandom_range(1, 0));
                drive(1'b1, ra_d, ra_a, ra_dir);
            end else begin
                drive(1'b0, 8'h00, 3'd0, 1'b0);
            end
            acc = cmd_valid && cmd_ready;
            if (acc) begin
                model = cmd_dir ? (cmd_data << cmd_amount) : (cmd_data >> cmd_amount);
                q.push_back(model);
                sent++;
            end
            step();
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("t6_unexpected", 32'(out_valid), 32'd0);
                end else begin
                    rd = q.pop_front();
                    chk("t6_data", 32'(out_data), 32'(rd));
                end
                got++;
            end
        end
        drive(1'b0, 8'h00, 3'd0, 1'b0);
        chk("t6_count", 32'(got), 32'd10);
        step();
`ifdef SHIFT_STATS_EN
        chk("t6_op_count", 32'(op_count), 32'd10);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
